// File: rtl/mdu_iterative.sv
// RV32M multiply/divide, one bit per cycle: latency XLEN+1 (1 for div-by-zero/overflow).
// No backpressure on results; busy=1 ignores start, flush aborts at the next edge.
module mdu_iterative #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state;
    logic [2:0]        op;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   divisor;
    logic              neg;
    logic [TAG_W-1:0]  tag;

    logic              a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   fast_quo, fast_rem;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sign_a   = a_signed && op_a[XLEN-1];
        sign_b   = b_signed && op_b[XLEN-1];
        abs_a    = sign_a ? -op_a : op_a;
        abs_b    = sign_b ? -op_b : op_b;
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = funct3[2] && !funct3[0] && (op_a == MOST_NEG) && (op_b == '1);
        fast_quo = div_zero ? '1 : op_a;
        fast_rem = div_zero ? op_a : '0;
    end

    // Multiply and divide share acc: low half starts as |a|, high half as 0.
    logic [XLEN-1:0]   acc_hi, acc_lo;
    logic [XLEN:0]     mul_sum, trial;
    logic [2*XLEN-1:0] acc_mul, acc_div;

    always_comb begin
        acc_hi  = acc[2*XLEN-1:XLEN];
        acc_lo  = acc[XLEN-1:0];
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, divisor} : {(XLEN+1){1'b0}});
        acc_mul = {mul_sum, acc_lo[XLEN-1:1]};
        // Partial remainder stays below divisor, so the dropped acc_hi MSB is always 0.
        trial   = {acc_hi, acc_lo[XLEN-1]} - {1'b0, divisor};
        acc_div = trial[XLEN] ? {acc_hi[XLEN-2:0], acc_lo, 1'b0}
                              : {trial[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = neg ? -acc : acc;
        quo  = neg ? -acc_lo : acc_lo;
        rem  = neg ? -acc_hi : acc_hi;
        case (op)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op      <= '0;
            cnt     <= '0;
            acc     <= '0;
            divisor <= '0;
            neg     <= 1'b0;
            tag     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            tag_out <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            op      <= funct3;
                            tag     <= tag_in;
                            divisor <= abs_b;
                            cnt     <= '0;
                            busy    <= 1'b1;
                            if (div_zero || div_ovf) begin
                                // Architectural results are final; no sign correction.
                                acc   <= {fast_rem, fast_quo};
                                neg   <= 1'b0;
                                state <= FIX;
                            end else begin
                                acc   <= {{XLEN{1'b0}}, abs_a};
                                neg   <= (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        acc <= op[2] ? acc_div : acc_mul;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(XLEN-1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        result  <= fix_res;
                        tag_out <= tag;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed vector table, corner-case sequences,
// and randomized ops against an arithmetic reference model (XLEN=32 and 16).
module tb_mdu_iterative;
    logic        clk = 1'b0;
    logic        reset;
    logic        start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result;
    logic [4:0]  tag_in, tag_out;
    logic        busy, done;

    logic        h_start;
    logic [2:0]  h_funct3;
    logic [15:0] h_a, h_b, h_result;
    logic [4:0]  h_tag_in, h_tag_out;
    logic        h_busy, h_done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_exp;

    always #5 clk = ~clk;

    mdu_iterative #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .tag_in(tag_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .tag_out(tag_out)
    );

    mdu_iterative #(.XLEN(16), .TAG_W(5)) dut16 (
        .clk(clk), .reset(reset), .start(h_start), .funct3(h_funct3),
        .op_a(h_a), .op_b(h_b), .tag_in(h_tag_in), .flush(1'b0),
        .busy(h_busy), .done(h_done), .result(h_result), .tag_out(h_tag_out)
    );

    typedef struct {
        string       nm;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp_r;
        int          lat;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Exact RISC-V M semantics computed with 64-bit arithmetic, truncated to w bits.
    function automatic logic [31:0] model(input int w, input logic [2:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub, sa, sb, p, r64;
        longint      as_, bs_;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = a[w-1] ? (ua | ~mask) : ua;
        sb   = b[w-1] ? (ub | ~mask) : ub;
        as_  = $signed(sa);
        bs_  = $signed(sb);
        case (f)
            3'b000: begin p = ua * ub; r64 = p & mask; end
            3'b001: begin p = sa * sb; r64 = (p >> w) & mask; end
            3'b010: begin p = sa * ub; r64 = (p >> w) & mask; end
            3'b011: begin p = ua * ub; r64 = (p >> w) & mask; end
            3'b100, 3'b110: begin
                if (ub == 0)
                    r64 = (f == 3'b100) ? mask : ua;
                else if (ua == (64'd1 << (w - 1)) && ub == mask)
                    r64 = (f == 3'b100) ? ua : 64'd0;
                else
                    r64 = ((f == 3'b100) ? 64'(as_ / bs_) : 64'(as_ % bs_)) & mask;
            end
            3'b101:  r64 = (ub == 0) ? mask : (ua / ub);
            default: r64 = (ub == 0) ? ua : (ua % ub);
        endcase
        return r64[31:0];
    endfunction

    // Call at posedge+1 with the unit idle; hold keeps start high with junk operands while busy.
    task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tg,
                         input logic [31:0] exp_r, input int exp_lat, input bit hold);
        int lat, bcnt;
        start = 1'b1; funct3 = f; op_a = a; op_b = b; tag_in = tg;
        @(posedge clk); #1;
        start = hold;
        if (hold) begin
            funct3 = ~f; op_a = ~a; op_b = b ^ 32'h5A5A_0001; tag_in = ~tg;
        end
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({nm, " latency"}, 64'(lat), 64'(exp_lat));
        check({nm, " busy cycles"}, 64'(bcnt), 64'(exp_lat));
        check({nm, " result"}, {32'd0, result}, {32'd0, exp_r});
        check({nm, " tag"}, {59'd0, tag_out}, {59'd0, tg});
        check({nm, " busy at done"}, {63'd0, busy}, 64'd0);
        last_exp = exp_r;
    endtask

    vec_t vecs[$];

    initial begin
        logic        saw_done;
        int          lat;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        int          mode, rlat;

        vecs.push_back('{"mul_7_m3",      3'b000, 32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33});
        vecs.push_back('{"mulh",          3'b001, 32'h80000000, 32'hFFFFFFFF, 5'd1,  32'h00000000, 33});
        vecs.push_back('{"mulhu",         3'b011, 32'h80000000, 32'hFFFFFFFF, 5'd2,  32'h7FFFFFFF, 33});
        vecs.push_back('{"mulhsu",        3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd3,  32'h80000000, 33});
        vecs.push_back('{"div_m20_6",     3'b100, 32'hFFFFFFEC, 32'd6,        5'd4,  32'hFFFFFFFD, 33});
        vecs.push_back('{"rem_m20_6",     3'b110, 32'hFFFFFFEC, 32'd6,        5'd6,  32'hFFFFFFFE, 33});
        vecs.push_back('{"divu_m20_6",    3'b101, 32'hFFFFFFEC, 32'd6,        5'd7,  32'h2AAAAAA7, 33});
        vecs.push_back('{"div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h80000000, 1});
        vecs.push_back('{"divu_by0",      3'b101, 32'd42,       32'd0,        5'd9,  32'hFFFFFFFF, 1});
        vecs.push_back('{"rem_by0",       3'b110, 32'd42,       32'd0,        5'd10, 32'd42,       1});
        vecs.push_back('{"rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,        1});
        vecs.push_back('{"divu_no_fast",  3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        33});
        vecs.push_back('{"remu_7_big",    3'b111, 32'd7,        32'hFFFFFFFF, 5'd13, 32'd7,        33});

        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0; tag_in = '0;
        h_start = 1'b0; h_funct3 = '0; h_a = '0; h_b = '0; h_tag_in = '0;
        last_exp = '0;
        #2;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset result", {32'd0, result}, 64'd0);
        check("reset tag", {59'd0, tag_out}, 64'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i])
            do_op(vecs[i].nm, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].tag,
                  vecs[i].exp_r, vecs[i].lat, (i % 3) == 1);

        // Flush a DIV when its counter reads 10, then issue a MUL straight after.
        start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd7; tag_in = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            saw_done |= done;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        saw_done |= done;
        check("flush busy", {63'd0, busy}, 64'd0);
        check("flush no done", {63'd0, saw_done}, 64'd0);
        check("flush result kept", {32'd0, result}, {32'd0, last_exp});
        do_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 33, 1'b0);

        // Randomized ops against the model.
        for (int n = 0; n < 40; n++) begin
            rf   = 3'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) rb = 32'd0;
            else if (mode == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            else if (mode == 2) rb = 32'($urandom_range(1, 15));
            rlat = (rf[2] && (rb == 32'd0 ||
                    (!rf[0] && ra == 32'h80000000 && rb == 32'hFFFFFFFF))) ? 1 : 33;
            do_op("random", rf, ra, rb, 5'($urandom_range(0, 31)),
                  model(32, rf, ra, rb), rlat, $urandom_range(0, 3) == 0);
        end

        // XLEN=16: start held through busy, second op accepted in the done cycle.
        h_start = 1'b1; h_funct3 = 3'b011; h_a = 16'hFFFF; h_b = 16'hFFFF; h_tag_in = 5'd9;
        @(posedge clk); #1;
        h_funct3 = 3'b100; h_a = 16'hFF9C; h_b = 16'h0007; h_tag_in = 5'd10;
        lat = 0;
        while (!h_done && lat < 100) begin @(posedge clk); #1; lat++; end
        check("x16 first latency", 64'(lat), 64'd17);
        check("x16 first result", {48'd0, h_result}, {32'd0, model(16, 3'b011, 32'hFFFF, 32'hFFFF)});
        check("x16 first tag", {59'd0, h_tag_out}, 64'd9);
        @(posedge clk); #1;
        check("x16 b2b accept busy", {63'd0, h_busy}, 64'd1);
        check("x16 done pulse", {63'd0, h_done}, 64'd0);
        h_start = 1'b0;
        lat = 0;
        while (!h_done && lat < 100) begin @(posedge clk); #1; lat++; end
        check("x16 second latency", 64'(lat), 64'd17);
        check("x16 second result", {48'd0, h_result}, {32'd0, model(16, 3'b100, 32'hFF9C, 32'h7)});
        check("x16 second tag", {59'd0, h_tag_out}, 64'd10);

        // Asynchronous reset mid-CALC clears outputs without waiting for an edge.
        start = 1'b1; funct3 = 3'b000; op_a = 32'h1234; op_b = 32'h5678; tag_in = 5'd30;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async reset busy", {63'd0, busy}, 64'd0);
        check("async reset done", {63'd0, done}, 64'd0);
        check("async reset result", {32'd0, result}, 64'd0);
        check("async reset tag", {59'd0, tag_out}, 64'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        do_op("mul_after_reset", 3'b000, 32'h1234, 32'h5678, 5'd30, 32'h06260060, 33, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
